// File: rtl/mux_4_1_rr_arb.sv
// Round-robin arbiter driving the select pins of a shared 4:1 mux.
// Optional grant hold limit enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux_4_1_rr_arb #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last;

  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic [3:0] others;
  logic       owner_req;
  logic       do_grant;
  logic       go_idle;
  logic [1:0] grant_idx;

  // An illegal parameter set leaves this marker block in the elaborated hierarchy.
  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param_combo
  end

  // Returns {found, index} of the first candidate after base, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!res[2] && cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While granting, last always equals the owner, so gnt doubles as the owner mask.
  assign others    = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign pick_idle = rr_pick(req, last);
  assign pick_next = rr_pick(others, last);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_expired;

  assign hold_expired = (hold_cnt == HOLD_LAST);

  // Counter clears on each new grant and saturates once the hold window is used up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (do_grant) begin
      hold_cnt <= '0;
    end else if (state == GRANT && !hold_expired) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    grant_idx = pick_idle[1:0];
    case (state)
      IDLE: begin
        do_grant = pick_idle[2];
      end
      GRANT: begin
        grant_idx = pick_next[1:0];
        if (!owner_req) begin
          do_grant = pick_next[2];
          go_idle  = !pick_next[2];
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        else if (hold_expired && pick_next[2]) begin
          do_grant = 1'b1;
        end
`endif
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
  end

  // Selects keep their last value when going idle so the mux output does not glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 2'd3;
      gnt   <= 4'b0000;
      s1    <= 1'b0;
      s0    <= 1'b0;
      valid <= 1'b0;
    end else if (do_grant) begin
      state <= GRANT;
      last  <= grant_idx;
      gnt   <= 4'b0001 << grant_idx;
      s1    <= grant_idx[1];
      s0    <= grant_idx[0];
      valid <= 1'b1;
    end else if (go_idle) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (!rst_n) valid == (gnt != 4'b0000));
  a_select : assert property (@(posedge clk) disable iff (!rst_n)
                              valid |-> (gnt == (4'b0001 << {s1, s0})));

endmodule

// File: tb/tb_mux_4_1_rr_arb.sv
// Randomised bench for mux_4_1_rr_arb against a queue-free integer reference model.
// Follows the MUX_ARB_HOLD_LIMIT_EN setting of the build.
module tb_mux_4_1_rr_arb;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;

  int total;
  int bad;

  // Reference state: owner is -1 when nobody holds the mux.
  int mOwner;
  int mLast;
  int mSel;
  int mHold;

  mux_4_1_rr_arb #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mLast  = 3;
    mSel   = 0;
    mHold  = 0;
  endtask

  function automatic int nextAfter(input logic [3:0] r, input int start, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic modelGive(input int w);
    mOwner = w;
    mLast  = w;
    mSel   = w;
    mHold  = 0;
  endtask

  task automatic modelStep(input logic [3:0] r);
    int w;
    if (mOwner < 0) begin
      w = nextAfter(r, mLast, -1);
      if (w >= 0) modelGive(w);
    end else begin
      w = nextAfter(r, mOwner, mOwner);
      if (r[mOwner]) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
        if (mHold == MAX_HOLD - 1 && w >= 0) modelGive(w);
        else if (mHold < MAX_HOLD - 1) mHold++;
`endif
      end else if (w >= 0) begin
        modelGive(w);
      end else begin
        mOwner = -1;
      end
    end
  endtask

  // Drive req for one cycle, advance the model on the edge, then compare.
  task automatic applyStimulus(input logic [3:0] r, input string tag);
    logic [3:0] eg;
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
    eg = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eg));
    checkOutput({tag, ".sel"}, 32'({s1, s0}), 32'(mSel));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(mOwner >= 0));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] e;
    total = 0;
    bad   = 0;
    req   = 4'b0000;
    rst_n = 1'b0;
    modelReset();
    #12;
    checkOutput("rst.gnt", 32'(gnt), 32'h0);
    checkOutput("rst.sel", 32'({s1, s0}), 32'h0);
    checkOutput("rst.valid", 32'(valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b0000, "idle");
    applyStimulus(4'b0001, "single");
    checkOutput("single.gnt_exp", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, "single_drop");
    checkOutput("single_drop.gnt", 32'(gnt), 32'h0);

    // Rotating ownership with each owner briefly dropping its request.
    doReset();
    applyStimulus(4'b1111, "rot_start");
    checkOutput("rot_start.gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, "rot_hold");
      r = 4'b1111 & ~(4'b0001 << k);
      applyStimulus(r, "rot_drop");
      e = 4'b0001 << ((k + 1) % 4);
      checkOutput("rot.gnt", 32'(gnt), 32'(e));
      checkOutput("rot.sel", 32'({s1, s0}), 32'((k + 1) % 4));
      checkOutput("rot.valid", 32'(valid), 32'h1);
    end

    // Wrap past index 3 from owner 2.
    doReset();
    applyStimulus(4'b0100, "wrap_own");
    applyStimulus(4'b0101, "wrap_hold");
    checkOutput("wrap_hold.gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0001, "wrap_drop");
    checkOutput("wrap.gnt", 32'(gnt), 32'h1);
    checkOutput("wrap.sel", 32'({s1, s0}), 32'h0);

    // Simultaneous arrival from idle with last=0, then idle keeps selects.
    applyStimulus(4'b0000, "simul_idle");
    applyStimulus(4'b1010, "simul");
    checkOutput("simul.gnt", 32'(gnt), 32'h2);
    applyStimulus(4'b1000, "simul_next");
    checkOutput("simul_next.gnt", 32'(gnt), 32'h8);
    applyStimulus(4'b0000, "hold_sel");
    checkOutput("hold_sel.sel", 32'({s1, s0}), 32'h3);
    checkOutput("hold_sel.valid", 32'(valid), 32'h0);

    // Pulse that comes and goes between edges is never granted.
    req = 4'b0010;
    #2;
    req = 4'b0000;
    applyStimulus(4'b0000, "glitch");

    // Sustained contention and lone requester long enough to expose any hold limit.
    doReset();
    for (int k = 0; k < 3 * MAX_HOLD; k++) applyStimulus(4'b0011, "hold_pair");
    applyStimulus(4'b0000, "hold_clear");
    for (int k = 0; k < 2 * MAX_HOLD; k++) applyStimulus(4'b0001, "hold_solo");

    // Asynchronous reset in the middle of a grant.
    applyStimulus(4'b0100, "areset_pre");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset.gnt", 32'(gnt), 32'h0);
    checkOutput("areset.sel", 32'({s1, s0}), 32'h0);
    checkOutput("areset.valid", 32'(valid), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, "areset_ptr");
    checkOutput("areset_ptr.gnt", 32'(gnt), 32'h1);

    // Random sticky requests with occasional asynchronous resets.
    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      applyStimulus(r, "rand");
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rand_rst.gnt", 32'(gnt), 32'h0);
        modelReset();
        #2;
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
